// File: rtl/expand_a_sched.sv
// Sequencer that walks the K x L matrix A through a shared uniform sampler:
// one seed load, then one sampler run per (i,j) with index tagging of each bundle.
module expand_a_sched #(
  parameter int K = 6,
  parameter int L = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] rho_i,
  input  logic        valid_i,
  output logic        ready_i,
  output logic        smp_start,
  output logic        smp_resample,
  output logic [3:0]  smp_i,
  output logic [3:0]  smp_j,
  output logic [63:0] smp_seed,
  output logic        smp_valid_i,
  input  logic        smp_ready_i,
  input  logic        smp_valid_o,
  output logic        smp_ready_o,
  input  logic        smp_done,
  output logic        valid_o,
  input  logic        ready_o,
  output logic [3:0]  poly_i,
  output logic [3:0]  poly_j,
  output logic [7:0]  coef_idx,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_SEED   = 3'd2,
    S_RUN    = 3'd3,
    S_NEXT   = 3'd4,
    S_FIN    = 3'd5
  } state_t;

  localparam logic [3:0] I_LAST = 4'(K - 1);
  localparam logic [3:0] J_LAST = 4'(L - 1);

  state_t      state_q, state_d;
  logic [3:0]  i_q, i_d;
  logic [3:0]  j_q, j_d;
  logic [7:0]  coef_q, coef_d;
  logic [1:0]  wcnt_q, wcnt_d;
  logic        err_q, err_d;
  logic        seed_hs;
  logic        bund_hs;

  assign seed_hs = valid_i && smp_ready_i;
  assign bund_hs = smp_valid_o && ready_o;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    coef_d  = coef_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LAUNCH;
          i_d     = 4'd0;
          j_d     = 4'd0;
          coef_d  = 8'd0;
          wcnt_d  = 2'd0;
          err_d   = 1'b0;
        end
      end
      S_LAUNCH: state_d = S_SEED;
      S_SEED: begin
        if (seed_hs) begin
          wcnt_d = wcnt_q + 2'd1;
          if (wcnt_q == 2'd3) begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (bund_hs) begin
          coef_d = coef_q + 8'd4;
        end
        // Completion must land on the handshake of the 64th bundle (tag 252).
        if (smp_done) begin
          if ((coef_q != 8'd252) || !bund_hs) begin
            err_d = 1'b1;
          end
          if ((i_q == I_LAST) && (j_q == J_LAST)) begin
            state_d = S_FIN;
          end else begin
            state_d = S_NEXT;
            coef_d  = 8'd0;
            if (j_q == J_LAST) begin
              j_d = 4'd0;
              i_d = i_q + 4'd1;
            end else begin
              j_d = j_q + 4'd1;
            end
          end
        end
      end
      S_NEXT:  state_d = S_RUN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      i_q     <= 4'd0;
      j_q     <= 4'd0;
      coef_q  <= 8'd0;
      wcnt_q  <= 2'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      coef_q  <= coef_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
    end
  end

  // Handshakes pass through only in their own phase; pulses decode from the state flop.
  assign busy         = (state_q == S_LAUNCH) || (state_q == S_SEED) ||
                        (state_q == S_RUN)    || (state_q == S_NEXT);
  assign done         = (state_q == S_FIN);
  assign smp_start    = (state_q == S_LAUNCH);
  assign smp_resample = (state_q == S_NEXT);
  assign ready_i      = (state_q == S_SEED) && smp_ready_i;
  assign smp_valid_i  = (state_q == S_SEED) && valid_i;
  assign smp_seed     = (state_q == S_SEED) ? rho_i : 64'd0;
  assign valid_o      = (state_q == S_RUN) && smp_valid_o;
  assign smp_ready_o  = (state_q == S_RUN) && ready_o;
  assign smp_i        = i_q;
  assign smp_j        = j_q;
  assign poly_i       = i_q;
  assign poly_j       = j_q;
  assign coef_idx     = coef_q;
  assign err          = err_q;

endmodule

// File: tb/tb_expand_a_sched.sv
// Directed bench for expand_a_sched with a behavioural sampler that emits a
// configurable number of bundles per polynomial and a negedge scoreboard.
module tb_expand_a_sched;
  localparam int K  = 6;
  localparam int L  = 5;
  localparam int NP = K * L;

  logic        clk = 1'b0;
  logic        rst, start, valid_i, smp_ready_i, ready_o;
  logic [63:0] rho_i;
  logic        ready_i, smp_start, smp_resample, smp_valid_i, smp_ready_o;
  logic [3:0]  smp_i, smp_j, poly_i, poly_j;
  logic [63:0] smp_seed;
  logic        smp_valid_o, smp_done, valid_o, busy, done, err;
  logic [7:0]  coef_idx;

  int checks = 0;
  int errors = 0;

  logic [63:0] seed_tab [4] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                64'hA5A5_5A5A_F00F_0FF0, 64'h1111_2222_3333_4444};

  expand_a_sched #(.K(K), .L(L)) dut (
    .clk(clk), .rst(rst), .start(start), .rho_i(rho_i), .valid_i(valid_i),
    .ready_i(ready_i), .smp_start(smp_start), .smp_resample(smp_resample),
    .smp_i(smp_i), .smp_j(smp_j), .smp_seed(smp_seed), .smp_valid_i(smp_valid_i),
    .smp_ready_i(smp_ready_i), .smp_valid_o(smp_valid_o), .smp_ready_o(smp_ready_o),
    .smp_done(smp_done), .valid_o(valid_o), .ready_o(ready_o), .poly_i(poly_i),
    .poly_j(poly_j), .coef_idx(coef_idx), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Sampler model: goes active after the 4th seed word or on re_sample, emits m_nb bundles.
  int   m_nb = 64;
  logic m_act;
  int   m_cnt;
  int   m_seeds;
  assign smp_valid_o = m_act;
  assign smp_done    = m_act && (m_cnt == m_nb - 1) && ready_o;

  always @(posedge clk) begin
    if (rst) begin
      m_act <= 1'b0; m_cnt <= 0; m_seeds <= 0;
    end else begin
      if (smp_start) m_seeds <= 0;
      else if (smp_valid_i && smp_ready_i) begin
        m_seeds <= m_seeds + 1;
        if (m_seeds == 3) begin m_act <= 1'b1; m_cnt <= 0; end
      end
      if (smp_resample) begin m_act <= 1'b1; m_cnt <= 0; end
      else if (m_act && ready_o) begin
        m_cnt <= m_cnt + 1;
        if (m_cnt == m_nb - 1) m_act <= 1'b0;
      end
    end
  end

  // Scoreboard counters, cleared by each sampler start pulse.
  int   cyc = 0, bip = 0, exp_i = 0, exp_j = 0;
  int   n_bund = 0, n_sdone = 0, n_resmp = 0, n_done = 0, n_seed = 0, tot_start = 0;
  int   last_sd = 0, four_cyc = 0;
  logic seen4 = 1'b0, err_at_done = 1'b0, rnd_ready = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (smp_start) begin
      bip <= 0; exp_i <= 0; exp_j <= 0; n_bund <= 0; n_sdone <= 0;
      n_resmp <= 0; n_done <= 0; n_seed <= 0; tot_start <= tot_start + 1;
    end
    if (smp_valid_i && smp_ready_i) begin
      check_eq("seed_word", smp_seed, seed_tab[n_seed[1:0]]);
      n_seed <= n_seed + 1;
      if (n_seed == 3) begin seen4 <= 1'b1; four_cyc <= cyc; end
    end
    if (seen4 && (cyc == four_cyc + 1)) begin
      if (!rnd_ready) check_eq("run_entry", {63'd0, smp_ready_o}, 64'd1);
      seen4 <= 1'b0;
    end
    if (valid_o && ready_o) begin
      check_eq("coef_idx", {56'd0, coef_idx}, 64'(bip * 4));
      check_eq("poly_i", {60'd0, poly_i}, 64'(exp_i));
      check_eq("poly_j", {60'd0, poly_j}, 64'(exp_j));
      n_bund <= n_bund + 1;
      if (bip == m_nb - 1) begin
        bip <= 0;
        if (exp_j == L - 1) begin exp_j <= 0; exp_i <= exp_i + 1; end
        else exp_j <= exp_j + 1;
      end else bip <= bip + 1;
    end
    if (smp_done) begin n_sdone <= n_sdone + 1; last_sd <= cyc; end
    if (smp_resample) n_resmp <= n_resmp + 1;
    if (done) begin
      n_done <= n_done + 1;
      check_eq("done_latency", 64'(cyc - last_sd), 64'd1);
      err_at_done <= err;
    end
  end

  initial begin
    ready_o = 1'b1;
    forever begin
      @(posedge clk); #1;
      ready_o = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic check_idle_outputs(input string tag);
    check_eq(tag, {55'd0, busy, done, err, ready_i, smp_start, smp_resample,
                   smp_valid_i, smp_ready_o, valid_o}, 64'd0);
    check_eq({tag, "_idx"}, {48'd0, poly_i, poly_j, coef_idx}, 64'd0);
  endtask

  task automatic send_seed(input int gap);
    for (int w = 0; w < 4; w++) begin
      valid_i = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      rho_i   = seed_tab[w];
      valid_i = 1'b1;
      begin
        int t = 0;
        @(negedge clk);
        while (!ready_i && t < 50) begin @(negedge clk); t++; end
        if (!ready_i) check_eq("seed_timeout", {63'd0, ready_i}, 64'd1);
      end
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
    rho_i   = 64'd0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_one(input int nb, input int gap, input logic rnd,
                         input logic exp_err, input logic poke);
    int t = 0;
    m_nb = nb;
    rnd_ready = rnd;
    start_pulse();
    check_eq("launch_pulse", {63'd0, smp_start}, 64'd1);
    check_eq("err_cleared", {63'd0, err}, 64'd0);
    send_seed(gap);
    if (poke) begin
      repeat (10) begin @(posedge clk); #1; end
      start_pulse();
    end
    @(negedge clk);
    while (!done && t < 20000) begin @(negedge clk); t++; end
    check_eq("done_seen", {63'd0, done}, 64'd1);
    if (poke) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    repeat (3) begin @(posedge clk); #1; end
    rnd_ready = 1'b0;
    check_eq("bundles", 64'(n_bund), 64'(nb * NP));
    check_eq("smp_done_cnt", 64'(n_sdone), 64'(NP));
    check_eq("resample_cnt", 64'(n_resmp), 64'(NP - 1));
    check_eq("done_cnt", 64'(n_done), 64'd1);
    check_eq("err_final", {63'd0, err}, {63'd0, exp_err});
    check_eq("err_at_done", {63'd0, err_at_done}, {63'd0, exp_err});
    check_eq("busy_after", {63'd0, busy}, 64'd0);
    check_eq("final_ij", {56'd0, poly_i, poly_j}, {56'd0, 4'(K - 1), 4'(L - 1)});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; valid_i = 1'b0; rho_i = 64'd0; smp_ready_i = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check_idle_outputs("reset_state");
    start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    check_idle_outputs("rst_over_start");
    @(posedge clk); #1;
    check_eq("idle_hold", {63'd0, busy}, 64'd0);

    run_one(64, 0, 1'b0, 1'b0, 1'b1);
    run_one(64, 2, 1'b0, 1'b0, 1'b0);
    run_one(64, 0, 1'b1, 1'b0, 1'b0);
    run_one(60, 0, 1'b0, 1'b1, 1'b0);
    run_one(64, 1, 1'b0, 1'b0, 1'b0);

    // Abort a run at (1,2) with reset, then a clean run from (0,0).
    m_nb = 64;
    start_pulse();
    send_seed(0);
    begin
      int t = 0;
      @(negedge clk);
      while (!(poly_i == 4'd1 && poly_j == 4'd2 && smp_ready_o) && t < 5000) begin
        @(negedge clk); t++;
      end
      check_eq("reach_1_2", {56'd0, poly_i, poly_j}, 64'h12);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("mid_run_reset");
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("idle_after_rst", {63'd0, busy}, 64'd0);
    run_one(64, 0, 1'b0, 1'b0, 1'b0);

    check_eq("accepted_starts", 64'(tot_start), 64'd7);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/expand_a_sched.md
EXPAND_A_SCHED -- requirements
Module: expand_a_sched

Interface
REQ-001 K, default 6: number of matrix rows (i range 0..K-1), legal 1..15.
REQ-002 L, default 5: number of matrix columns (j range 0..L-1), legal 1..15.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  request expansion of full K x L matrix A.
REQ-006 rho_i  in  64  seed word from upstream.
REQ-007 valid_i  in  1  rho_i valid.
REQ-008 ready_i  out  1  seed word accepted when valid_i && ready_i.
REQ-009 smp_start  out  1  one-cycle start pulse to uniform sampler.
REQ-010 smp_resample  out  1  one-cycle re_sample pulse to sampler (seed reuse).
REQ-011 smp_i  out  4  row index to sampler; smp_j  out  4  column index to sampler.
REQ-012 smp_seed  out  64  seed word to sampler; smp_valid_i  out  1; smp_ready_i  in  1.
REQ-013 smp_valid_o  in  1  sampler 4-coefficient bundle valid; smp_ready_o  out  1.
REQ-014 smp_done  in  1  sampler finished current polynomial.
REQ-015 valid_o  out  1; ready_o  in  1  downstream bundle handshake (data bypasses this block).
REQ-016 poly_i  out  4; poly_j  out  4; coef_idx  out  8  index tags of bundle on bus.
REQ-017 busy  out  1; done  out  1  one-cycle completion pulse; err  out  1  sticky count mismatch.

Function
REQ-018 States: IDLE, LAUNCH, SEED, RUN, NEXT, FIN; encoding free.
REQ-019 IDLE: busy=0, all handshake outputs 0; start=1 -> LAUNCH, i=j=0, coef_idx=0, err=0.
REQ-020 start in any state other than IDLE SHALL be ignored.
REQ-021 LAUNCH: smp_start=1 exactly one cycle, smp_i/smp_j=0 -> SEED.
REQ-022 SEED: ready_i=smp_ready_i, smp_valid_i=valid_i, smp_seed=rho_i (combinational pass-through); 2-bit word counter counts handshakes.
REQ-023 SEED exits to RUN on 4th seed handshake; ready_i=0 in all other states.
REQ-024 RUN: valid_o=smp_valid_o, smp_ready_o=ready_o; each valid_o&&ready_o -> coef_idx += 4.
REQ-025 poly_i/poly_j = current i/j, smp_i/smp_j = i/j, held stable for entire polynomial.
REQ-026 RUN on smp_done: if coef_idx (pre-increment, this cycle) != 252 or no handshake this cycle -> err=1 (sticky until next start).
REQ-027 smp_done with i=K-1, j=L-1 -> FIN; else -> NEXT, j+1 wrapping to 0 with i+1 (j inner, i outer), coef_idx=0.
REQ-028 NEXT: smp_resample=1 exactly one cycle with new i/j -> RUN; seed not re-sent.
REQ-029 FIN: done=1 one cycle, busy=0 -> IDLE; i, j, coef_idx hold final values until next start.
REQ-030 busy=1 in LAUNCH, SEED, RUN, NEXT.
REQ-031 Total handshakes per start: 64*K*L bundles, exactly K*L smp_done, 1 smp_start, K*L-1 smp_resample.
REQ-032 Back-pressure: ready_o=0 SHALL stall without dropping or duplicating bundles; coef_idx unchanged.
REQ-033 Latency: done asserts cycle after last smp_done; NEXT adds exactly 1 cycle between polynomials.

Reset
REQ-034 rst=1 at any clock edge -> IDLE next cycle, regardless of state.
REQ-035 Reset values: busy, done, err, ready_i, smp_start, smp_resample, smp_valid_i, smp_ready_o, valid_o = 0; i, j, coef_idx, word counter = 0.
REQ-036 rst coinciding with start SHALL give IDLE (rst wins); rst mid-RUN leaves sampler reset to its owner.

Verification
REQ-037 K=2,L=2, start, 4 seed words, ready_o=1 -> 256 bundles, (i,j) order 00,01,10,11, 3 smp_resample pulses, done 1 cycle after 4th smp_done, err=0.
REQ-038 Seed with valid_i gaps (1 valid every 3 cycles) -> exactly 4 handshakes, RUN entered cycle after 4th, smp_seed equals rho_i each handshake.
REQ-039 Random ready_o (50%) over K=6,L=5 -> 1920 bundles, coef_idx sequence 0,4..252 per polynomial, no gaps, done once.
REQ-040 Model sampler asserting smp_done after 60 bundles -> err=1, stays 1 through FIN, cleared by next start.
REQ-041 rst asserted mid-RUN (i=1,j=2) -> IDLE next cycle, all outputs at reset values; subsequent start completes normally from i=j=0.
REQ-042 start pulsed during RUN and FIN -> ignored; only one done per accepted start.
